// File: rtl/csi_rx_byte_align_if.sv
`default_nettype none
// ============================================================================
// Module      : csi_rx_byte_align_if
// Description : Bundle between the lane deserialiser / packet stage and the
//               CSI byte aligner. "master" is the surrounding system (drives
//               the raw stream and packet controls); "slave" is the aligner.
//               CSI_SYNC_ERR_TOLERANT_EN adds the sync_corrected flag.
// Revision    : 1.0  initial release
// ============================================================================
interface csi_rx_byte_align_if;
  logic [7:0] deser_in;
  logic       wait_for_sync;
  logic       packet_done;
  logic [7:0] data_out;
  logic       data_vld;
  logic       locked;
  logic [2:0] offset;
  logic       sync_timeout;
`ifdef CSI_SYNC_ERR_TOLERANT_EN
  logic       sync_corrected;

  modport master (
    output deser_in, wait_for_sync, packet_done,
    input  data_out, data_vld, locked, offset, sync_timeout, sync_corrected
  );

  modport slave (
    input  deser_in, wait_for_sync, packet_done,
    output data_out, data_vld, locked, offset, sync_timeout, sync_corrected
  );
`else
  modport master (
    output deser_in, wait_for_sync, packet_done,
    input  data_out, data_vld, locked, offset, sync_timeout
  );

  modport slave (
    input  deser_in, wait_for_sync, packet_done,
    output data_out, data_vld, locked, offset, sync_timeout
  );
`endif
endinterface
`default_nettype wire

// File: rtl/csi_rx_byte_align.sv
`default_nettype none
// ============================================================================
// Module      : csi_rx_byte_align
// Description : Hunts the HS sync byte at any of 8 bit offsets in the raw
//               deserialiser stream, locks that offset and emits byte-aligned
//               payload until packet_done. Reports hunt timeouts.
//               Optional macro CSI_SYNC_ERR_TOLERANT_EN: also accept a sync
//               byte with a single bit error (flagged on sync_corrected).
// Revision    : 1.0  initial release
// ============================================================================
module csi_rx_byte_align #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hB8,
  parameter logic [15:0] HUNT_TIMEOUT = 16'd4096
) (
  input  wire logic          byte_clock,
  input  wire logic          reset_n,
  csi_rx_byte_align_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [15:0] C_TIMER_LAST = HUNT_TIMEOUT - 16'd1;

  state_t      state_q, state_d;
  logic [7:0]  curr_q, curr_d;
  logic [7:0]  prev_q, prev_d;
  logic [15:0] timer_q, timer_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        data_vld_q, data_vld_d;
  logic        locked_q, locked_d;
  logic [2:0]  offset_q, offset_d;
  logic        sync_timeout_q, sync_timeout_d;
`ifdef CSI_SYNC_ERR_TOLERANT_EN
  logic        sync_corrected_q, sync_corrected_d;
  logic [7:0]  near_hit;
  logic        hit_near;
`endif

  // Two-byte window {curr, prev}; the top bit can never be part of a
  // candidate (offset 7 tops out at bit 14), so it is left out.
  logic [14:0] window;
  logic [7:0]  exact_hit;
  logic        hit_any;
  logic [2:0]  hit_k;

  assign window = {curr_q[6:0], prev_q};

  // Per-offset candidate detection with the HS-zero qualifier below it.
  for (genvar k = 0; k < 8; k++) begin : g_cand
    localparam logic [14:0] C_QMASK = 15'((32'd1 << k) - 32'd1);
    logic qual;
    assign qual         = ((window & C_QMASK) == 15'd0);
    assign exact_hit[k] = qual && (window[k +: 8] == SYNC_BYTE);
`ifdef CSI_SYNC_ERR_TOLERANT_EN
    assign near_hit[k]  = qual && $onehot(window[k +: 8] ^ SYNC_BYTE);
`endif
  end

  // Pick the lowest matching offset; exact matches beat 1-bit matches.
  always_comb begin
    hit_any = 1'b0;
    hit_k   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (exact_hit[i]) begin
        hit_any = 1'b1;
        hit_k   = 3'(i);
      end
    end
`ifdef CSI_SYNC_ERR_TOLERANT_EN
    hit_near = 1'b0;
    if (!hit_any) begin
      for (int i = 7; i >= 0; i--) begin
        if (near_hit[i]) begin
          hit_any  = 1'b1;
          hit_near = 1'b1;
          hit_k    = 3'(i);
        end
      end
    end
`endif
  end

  // Next-state / next-output logic for the IDLE-HUNT-LOCKED machine.
  always_comb begin
    state_d        = state_q;
    prev_d         = curr_q;
    curr_d         = bus.deser_in;
    timer_d        = timer_q;
    data_out_d     = data_out_q;
    data_vld_d     = 1'b0;
    offset_d       = offset_q;
    sync_timeout_d = 1'b0;
`ifdef CSI_SYNC_ERR_TOLERANT_EN
    sync_corrected_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        timer_d = 16'd0;
        if (bus.wait_for_sync) state_d = ST_HUNT;
      end
      ST_HUNT: begin
        if (hit_any) begin
          state_d  = ST_LOCKED;
          offset_d = hit_k;
          timer_d  = 16'd0;
`ifdef CSI_SYNC_ERR_TOLERANT_EN
          sync_corrected_d = hit_near;
`endif
        end else if (!bus.wait_for_sync) begin
          state_d = ST_IDLE;
          timer_d = 16'd0;
        end else if (timer_q == C_TIMER_LAST) begin
          sync_timeout_d = 1'b1;
          timer_d        = 16'd0;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      ST_LOCKED: begin
        timer_d = 16'd0;
        // packet_done beats both output and any (ignored) match.
        if (bus.packet_done) begin
          state_d = bus.wait_for_sync ? ST_HUNT : ST_IDLE;
        end else begin
          data_out_d = window[offset_q +: 8];
          data_vld_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    locked_d = (state_d == ST_LOCKED);
  end

  // All state and registered outputs; synchronous active-low reset.
  always_ff @(posedge byte_clock) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      curr_q         <= 8'd0;
      prev_q         <= 8'd0;
      timer_q        <= 16'd0;
      data_out_q     <= 8'd0;
      data_vld_q     <= 1'b0;
      locked_q       <= 1'b0;
      offset_q       <= 3'd0;
      sync_timeout_q <= 1'b0;
`ifdef CSI_SYNC_ERR_TOLERANT_EN
      sync_corrected_q <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      curr_q         <= curr_d;
      prev_q         <= prev_d;
      timer_q        <= timer_d;
      data_out_q     <= data_out_d;
      data_vld_q     <= data_vld_d;
      locked_q       <= locked_d;
      offset_q       <= offset_d;
      sync_timeout_q <= sync_timeout_d;
`ifdef CSI_SYNC_ERR_TOLERANT_EN
      sync_corrected_q <= sync_corrected_d;
`endif
    end
  end

  assign bus.data_out     = data_out_q;
  assign bus.data_vld     = data_vld_q;
  assign bus.locked       = locked_q;
  assign bus.offset       = offset_q;
  assign bus.sync_timeout = sync_timeout_q;
`ifdef CSI_SYNC_ERR_TOLERANT_EN
  assign bus.sync_corrected = sync_corrected_q;
`endif

endmodule
`default_nettype wire
